ssemi_cic_interpolator: RTL and testbench
=========================================

# ssemi_cic_interpolator

Configurable CIC interpolation filter for the DAC/upsampling path, the transmit-side counterpart of the decimating CIC. Accepts low-rate signed samples on a valid/ready handshake and produces INTERPOLATION_FACTOR output samples per input. The comb section runs at the input rate, zero-stuffing upsamples, and the integrator section runs at the output (clock) rate. Output is scaled by a fixed arithmetic shift and saturated.

## Interface
- CIC_STAGES, 4: number of comb stages and integrator stages (N), 1..8
- DIFFERENTIAL_DELAY, 1: comb delay M, 1..4
- INTERPOLATION_FACTOR, 8: R, 2..256; output beats per accepted input
- INPUT_DATA_WIDTH, 16: signed input width
- ACC_WIDTH, 32: internal comb/integrator width; must be ≥ INPUT_DATA_WIDTH + N·log2(R·M) − log2(R)
- OUTPUT_DATA_WIDTH, 16: signed output width
- OUTPUT_SHIFT, 9: arithmetic right shift applied before saturation (9 = unity gain at defaults)
- i_clk  in  1  clock; one clock domain
- i_rst_n  in  1  reset, asynchronous, active-low
- i_enable  in  1  0 = synchronous clear of all state to reset values
- i_data  in  INPUT_DATA_WIDTH  signed input sample
- i_valid  in  1  input sample valid
- o_ready  out  1  block accepts i_data this cycle
- o_data  out  OUTPUT_DATA_WIDTH  signed interpolated output
- o_valid  out  1  o_data valid (one output per cycle while streaming)
- o_saturate  out  1  o_data clipped this beat
- o_underrun  out  1  one-cycle pulse: R beats finished with no new input available
- o_busy  out  1  state == RUN

## Operation
- States: IDLE (no sample held, integrators frozen), RUN (emitting beats). Counter phase 0..R-1.
- o_ready = i_enable && (state==IDLE || phase==R-1); decoded from registers only.
- Accept = i_valid && o_ready. On accept edge: comb chain updates, comb_out_q ← comb result, phase ← 0, state ← RUN.
- Comb stage k: y = x − x[n−M], x sign-extended to ACC_WIDTH; delay lines advance only on accept.
- Every RUN edge (a "beat"): integ[0] += (phase==0 ? comb_out_q : 0); integ[k] += integ[k−1] (pre-edge values); phase ← phase+1 unless phase==R-1.
- At phase==R-1 edge: accept → reload as above, stay RUN; no accept → state ← IDLE, o_underrun pulses next cycle.
- All comb/integrator arithmetic wraps modulo 2^ACC_WIDTH (no saturation inside; wrap is required for CIC correctness).
- Output: v = integ_next[N−1] >>> OUTPUT_SHIFT; o_data ← clip(v) to [−2^(OW−1), 2^(OW−1)−1]; o_saturate ← clipped; both registered on every RUN edge.
- o_valid ← (state==RUN) on every edge; low through IDLE. Integrator contents persist across IDLE; streaming resumes without transient.
- Steady-state DC gain before shift: (R·M)^N / R.

## Timing
- Reset (async) and i_enable=0 (sync): state IDLE, phase 0, all comb/integrator regs 0; o_ready 0 during reset, o_data 0, o_valid 0, o_saturate 0, o_underrun 0, o_busy 0.
- Input accepted at edge E0: it enters integ[0] at E1 and reaches o_data after edge E_N (latency N cycles from accept to first affected o_data).
- Back-to-back streaming with i_valid held high: exactly one accept every R cycles, o_valid continuously 1.
- i_valid rising while in IDLE: accepted same cycle (o_ready already 1).
- i_enable dropped mid-RUN: next edge clears everything; in-flight samples discarded; no underrun pulse.
- Async reset mid-RUN: immediate clear, outputs at reset values until first edge after release.
- i_valid with o_ready low: sample not consumed; source holds data.

## Test plan
- N=1, M=1, R=4, SHIFT=0, OW=32: impulse 100 then zeros streaming → o_data 100,100,100,100, then 0 onward; first 100 one cycle after E1.
- Defaults (N=4, R=8, SHIFT=9): DC 1000 streaming → o_data settles to 1000 (gain 4096/8=512, >>9), o_valid continuously 1, o_ready every 8th cycle.
- N=3, R=8, SHIFT=0, OW=16: DC 1000 → settles to 32767 with o_saturate=1; DC −1000 → −32768.
- Single sample then i_valid low → 8 beats, o_underrun one-cycle pulse, o_busy falls, integrators hold; new sample resumes output.
- i_enable low for one cycle mid-stream → all outputs and state return to reset values next cycle; restart reproduces impulse response from zero.
- Random input, random i_valid gaps, N/M/R sweep → o_data bit-exact against wrap-arithmetic reference model.

Source files
------------

// File: rtl/ssemi_cic_interpolator_if.sv
// ssemi_cic_interpolator_if
//   Sample stream and status bundle for the CIC interpolator.
//   master : sample source / consumer of the interpolated stream
//   slave  : the interpolator itself
//   Signals
//     i_enable   : 0 = synchronous clear of the filter
//     i_data     : signed low-rate input sample
//     i_valid    : i_data valid
//     o_ready    : filter accepts i_data this cycle
//     o_data     : signed interpolated output sample
//     o_valid    : o_data valid
//     o_saturate : o_data was clipped this beat
//     o_underrun : one-cycle pulse, a sample period ended with no new input
//     o_busy     : filter is emitting beats
interface ssemi_cic_interpolator_if #(
  parameter int INPUT_DATA_WIDTH  = 16,
  parameter int OUTPUT_DATA_WIDTH = 16
);
  logic                                i_enable;
  logic signed [INPUT_DATA_WIDTH-1:0]  i_data;
  logic                                i_valid;
  logic                                o_ready;
  logic signed [OUTPUT_DATA_WIDTH-1:0] o_data;
  logic                                o_valid;
  logic                                o_saturate;
  logic                                o_underrun;
  logic                                o_busy;

  modport master (
    output i_enable, i_data, i_valid,
    input  o_ready, o_data, o_valid, o_saturate, o_underrun, o_busy
  );

  modport slave (
    input  i_enable, i_data, i_valid,
    output o_ready, o_data, o_valid, o_saturate, o_underrun, o_busy
  );
endinterface

// File: rtl/ssemi_cic_interpolator.sv
// ssemi_cic_interpolator
//   CIC interpolation filter. Comb chain runs once per accepted input sample,
//   the sample is zero-stuffed to INTERPOLATION_FACTOR beats, and the
//   integrator chain runs once per beat. Output is arithmetically shifted by
//   OUTPUT_SHIFT and saturated to OUTPUT_DATA_WIDTH.
//   Ports
//     i_clk   : clock
//     i_rst_n : asynchronous active-low reset
//     bus     : sample stream / status bundle (slave side)
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | no sample held, integrators frozen, waiting for input
//   ST_RUN  | emitting one beat per cycle, phase counts 0..R-1
module ssemi_cic_interpolator #(
  parameter int CIC_STAGES           = 4,
  parameter int DIFFERENTIAL_DELAY   = 1,
  parameter int INTERPOLATION_FACTOR = 8,
  parameter int INPUT_DATA_WIDTH     = 16,
  parameter int ACC_WIDTH            = 32,
  parameter int OUTPUT_DATA_WIDTH    = 16,
  parameter int OUTPUT_SHIFT         = 9
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  ssemi_cic_interpolator_if.slave  bus
);

  localparam int N  = CIC_STAGES;
  localparam int M  = DIFFERENTIAL_DELAY;
  localparam int R  = INTERPOLATION_FACTOR;
  localparam int IW = INPUT_DATA_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam int OW = OUTPUT_DATA_WIDTH;
  localparam int PW = (R > 1) ? $clog2(R) : 1;

  localparam logic [PW-1:0] PHASE_LAST = PW'(R - 1);
  localparam logic [PW-1:0] PHASE_ONE  = PW'(1);

  // Clipping is only possible when the output is narrower than the accumulator.
  localparam bit            NEED_CLIP  = (OW < AW);
  localparam logic [AW-1:0] ONE_ACC    = AW'(1);
  localparam logic [AW-1:0] SAT_MAX_U  = (ONE_ACC << (OW - 1)) - ONE_ACC;

  typedef logic signed [AW-1:0] acc_t;

  localparam acc_t                 SAT_MAX = $signed(SAT_MAX_U);
  localparam acc_t                 SAT_MIN = ~SAT_MAX;
  localparam logic signed [OW-1:0] OUT_MAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] OUT_MIN = {1'b1, {(OW-1){1'b0}}};

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         phase_q, phase_d;
  acc_t                  comb_dly_q [N][M];
  acc_t                  comb_dly_d [N][M];
  acc_t                  comb_out_q, comb_out_d;
  acc_t                  integ_q [N];
  acc_t                  integ_d [N];
  logic signed [OW-1:0]  data_q, data_d;
  logic                  sat_q, sat_d;
  logic                  valid_q, valid_d;
  logic                  under_q, under_d;

  logic signed [IW-1:0]  in_sample;
  acc_t                  comb_x;
  acc_t                  shifted;
  logic signed [OW-1:0]  data_now;
  logic                  sat_now;
  logic                  phase_last;
  logic                  ready;
  logic                  accept;
  logic                  beat;

  assign in_sample = bus.i_data;

  always_comb begin
    phase_last = (phase_q == PHASE_LAST);
    // Reset gates ready so a source never sees a handshake while held in reset.
    ready      = i_rst_n && bus.i_enable && ((state_q == ST_IDLE) || phase_last);
    accept     = bus.i_valid && ready;
    beat       = (state_q == ST_RUN);

    // Comb chain: comb_x walks through the stages; delay lines shift on accept.
    comb_dly_d = comb_dly_q;
    comb_out_d = comb_out_q;
    comb_x     = acc_t'(in_sample);
    for (int k = 0; k < N; k++) begin
      if (accept) begin
        comb_dly_d[k][0] = comb_x;
        for (int j = 1; j < M; j++) begin
          comb_dly_d[k][j] = comb_dly_q[k][j-1];
        end
      end
      comb_x = comb_x - comb_dly_q[k][M-1];
    end
    if (accept) begin
      comb_out_d = comb_x;
    end

    // Integrators: zero-stuffed comb output enters only on phase 0; each later
    // stage adds the pre-edge value of the stage before it.
    integ_d = integ_q;
    if (beat) begin
      integ_d[0] = integ_q[0] + ((phase_q == '0) ? comb_out_q : '0);
      for (int k = 1; k < N; k++) begin
        integ_d[k] = integ_q[k] + integ_q[k-1];
      end
    end

    shifted  = integ_d[N-1] >>> OUTPUT_SHIFT;
    data_now = OW'(shifted);
    sat_now  = 1'b0;
    if (NEED_CLIP) begin
      if (shifted > SAT_MAX) begin
        data_now = OUT_MAX;
        sat_now  = 1'b1;
      end else if (shifted < SAT_MIN) begin
        data_now = OUT_MIN;
        sat_now  = 1'b1;
      end
    end

    state_d = state_q;
    phase_d = phase_q;
    data_d  = data_q;
    sat_d   = sat_q;
    valid_d = beat;
    under_d = 1'b0;

    if (beat) begin
      data_d = data_now;
      sat_d  = sat_now;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RUN;
          phase_d = '0;
        end
      end
      ST_RUN: begin
        if (phase_last) begin
          phase_d = '0;
          if (!accept) begin
            state_d = ST_IDLE;
            under_d = 1'b1;
          end
        end else begin
          phase_d = phase_q + PHASE_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!bus.i_enable) begin
      state_d    = ST_IDLE;
      phase_d    = '0;
      comb_out_d = '0;
      for (int k = 0; k < N; k++) begin
        integ_d[k] = '0;
        for (int j = 0; j < M; j++) begin
          comb_dly_d[k][j] = '0;
        end
      end
      data_d  = '0;
      sat_d   = 1'b0;
      valid_d = 1'b0;
      under_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      comb_out_q <= '0;
      for (int k = 0; k < N; k++) begin
        integ_q[k] <= '0;
        for (int j = 0; j < M; j++) begin
          comb_dly_q[k][j] <= '0;
        end
      end
      data_q  <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      comb_out_q <= comb_out_d;
      comb_dly_q <= comb_dly_d;
      integ_q    <= integ_d;
      data_q     <= data_d;
      sat_q      <= sat_d;
      valid_q    <= valid_d;
      under_q    <= under_d;
    end
  end

  assign bus.o_ready    = ready;
  assign bus.o_data     = data_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_saturate = sat_q;
  assign bus.o_underrun = under_q;
  assign bus.o_busy     = (state_q == ST_RUN);

endmodule

// File: tb/tb_ssemi_cic_interpolator.sv
// Bench for ssemi_cic_interpolator: four configurations run side by side and
// are compared every cycle against a closed-form CIC model (binomial comb
// coefficients, binomial integrator impulse response, modulo 2^ACC_WIDTH).
module tb_ssemi_cic_interpolator;

  localparam int ND = 4;
  localparam int AW = 32;
  localparam int P_N  [ND] = '{4, 1, 3, 2};
  localparam int P_M  [ND] = '{1, 1, 1, 3};
  localparam int P_R  [ND] = '{8, 4, 8, 5};
  localparam int P_SH [ND] = '{9, 0, 0, 3};
  localparam int P_OW [ND] = '{16, 32, 16, 12};

  localparam int MD_IDLE = 0, MD_IMP = 1, MD_DC = 2, MD_SINGLE = 3, MD_RAND = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              en  [ND];
  logic              vld [ND];
  logic signed [15:0] din [ND];

  longint d_data  [ND];
  logic   d_ready [ND];
  logic   d_valid [ND];
  logic   d_sat   [ND];
  logic   d_under [ND];
  logic   d_busy  [ND];

  ssemi_cic_interpolator_if #(.INPUT_DATA_WIDTH(16), .OUTPUT_DATA_WIDTH(16)) bus0 ();
  ssemi_cic_interpolator_if #(.INPUT_DATA_WIDTH(16), .OUTPUT_DATA_WIDTH(32)) bus1 ();
  ssemi_cic_interpolator_if #(.INPUT_DATA_WIDTH(16), .OUTPUT_DATA_WIDTH(16)) bus2 ();
  ssemi_cic_interpolator_if #(.INPUT_DATA_WIDTH(16), .OUTPUT_DATA_WIDTH(12)) bus3 ();

  ssemi_cic_interpolator #(
    .CIC_STAGES(4), .DIFFERENTIAL_DELAY(1), .INTERPOLATION_FACTOR(8), .INPUT_DATA_WIDTH(16),
    .ACC_WIDTH(32), .OUTPUT_DATA_WIDTH(16), .OUTPUT_SHIFT(9)
  ) u_dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus0));

  ssemi_cic_interpolator #(
    .CIC_STAGES(1), .DIFFERENTIAL_DELAY(1), .INTERPOLATION_FACTOR(4), .INPUT_DATA_WIDTH(16),
    .ACC_WIDTH(32), .OUTPUT_DATA_WIDTH(32), .OUTPUT_SHIFT(0)
  ) u_dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));

  ssemi_cic_interpolator #(
    .CIC_STAGES(3), .DIFFERENTIAL_DELAY(1), .INTERPOLATION_FACTOR(8), .INPUT_DATA_WIDTH(16),
    .ACC_WIDTH(32), .OUTPUT_DATA_WIDTH(16), .OUTPUT_SHIFT(0)
  ) u_dut2 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus2));

  ssemi_cic_interpolator #(
    .CIC_STAGES(2), .DIFFERENTIAL_DELAY(3), .INTERPOLATION_FACTOR(5), .INPUT_DATA_WIDTH(16),
    .ACC_WIDTH(32), .OUTPUT_DATA_WIDTH(12), .OUTPUT_SHIFT(3)
  ) u_dut3 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus3));

  assign bus0.i_enable = en[0];  assign bus0.i_valid = vld[0];  assign bus0.i_data = din[0];
  assign bus1.i_enable = en[1];  assign bus1.i_valid = vld[1];  assign bus1.i_data = din[1];
  assign bus2.i_enable = en[2];  assign bus2.i_valid = vld[2];  assign bus2.i_data = din[2];
  assign bus3.i_enable = en[3];  assign bus3.i_valid = vld[3];  assign bus3.i_data = din[3];

  assign d_data[0] = longint'(bus0.o_data);
  assign d_data[1] = longint'(bus1.o_data);
  assign d_data[2] = longint'(bus2.o_data);
  assign d_data[3] = longint'(bus3.o_data);
  assign d_ready[0] = bus0.o_ready;  assign d_valid[0] = bus0.o_valid;  assign d_sat[0] = bus0.o_saturate;
  assign d_ready[1] = bus1.o_ready;  assign d_valid[1] = bus1.o_valid;  assign d_sat[1] = bus1.o_saturate;
  assign d_ready[2] = bus2.o_ready;  assign d_valid[2] = bus2.o_valid;  assign d_sat[2] = bus2.o_saturate;
  assign d_ready[3] = bus3.o_ready;  assign d_valid[3] = bus3.o_valid;  assign d_sat[3] = bus3.o_saturate;
  assign d_under[0] = bus0.o_underrun;  assign d_busy[0] = bus0.o_busy;
  assign d_under[1] = bus1.o_underrun;  assign d_busy[1] = bus1.o_busy;
  assign d_under[2] = bus2.o_underrun;  assign d_busy[2] = bus2.o_busy;
  assign d_under[3] = bus3.o_underrun;  assign d_busy[3] = bus3.o_busy;

  // Model state: accepted inputs, their comb outputs and the beat index at
  // which each one enters the integrators.
  bit     m_run   [ND];
  int     m_phase [ND];
  longint m_beats [ND];
  longint m_x [ND][$];
  longint m_c [ND][$];
  longint m_s [ND][$];
  longint e_data  [ND];
  bit     e_valid [ND];
  bit     e_sat   [ND];
  bit     e_under [ND];
  bit     e_busy  [ND];
  bit     last_acc [ND];
  int     sent_cnt [ND];

  int     n_vec = 0;
  int     n_err = 0;
  int     mode = MD_IDLE;
  longint dc_val = 0;
  int     imp_cnt = 0;
  int     rdy_cnt = 0;
  int     nv_cnt = 0;
  int     under_cnt = 0;

  function automatic longint wrapw(longint v, int w);
    longint t;
    t = v <<< (64 - w);
    return t >>> (64 - w);
  endfunction

  function automatic longint binom(longint n, int k);
    longint r;
    if (n < k || n < 0) return 0;
    r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  function automatic longint clipv(longint v, int ow, output bit sat);
    longint mx, mn;
    mx  = (longint'(1) <<< (ow - 1)) - 1;
    mn  = -mx - 1;
    sat = 1'b0;
    if (v > mx) begin sat = 1'b1; return mx; end
    if (v < mn) begin sat = 1'b1; return mn; end
    return v;
  endfunction

  task automatic model_clear(int d);
    m_run[d] = 0; m_phase[d] = 0; m_beats[d] = 0;
    m_x[d].delete(); m_c[d].delete(); m_s[d].delete();
    e_data[d] = 0; e_valid[d] = 0; e_sat[d] = 0; e_under[d] = 0; e_busy[d] = 0;
  endtask

  function automatic bit model_ready(int d);
    return rst_n && en[d] && (!m_run[d] || m_phase[d] == P_R[d] - 1);
  endfunction

  task automatic model_step(int d, bit e, bit v, longint x, output bit acc);
    bit rdy, beat, s;
    longint y, c;
    int n, nx, idx;
    acc = 0;
    if (!e) begin model_clear(d); return; end
    n    = P_N[d];
    rdy  = !m_run[d] || m_phase[d] == P_R[d] - 1;
    acc  = v && rdy;
    beat = m_run[d];
    e_valid[d] = beat;
    e_under[d] = beat && (m_phase[d] == P_R[d] - 1) && !acc;
    if (beat) begin
      // N cascaded integrators (each later stage lagging one beat) have
      // impulse response C(t, N-1).
      y = 0;
      for (int k = 0; k < m_c[d].size(); k++)
        y += m_c[d][k] * binom(m_beats[d] - m_s[d][k], n - 1);
      y = wrapw(y, AW) >>> P_SH[d];
      e_data[d] = clipv(y, P_OW[d], s);
      e_sat[d]  = s;
      m_beats[d]++;
    end
    if (acc) begin
      // N combs of delay M: sum_j (-1)^j C(N,j) x[n - jM].
      m_x[d].push_back(x);
      nx = m_x[d].size();
      c  = 0;
      for (int j = 0; j <= n; j++) begin
        idx = nx - 1 - j * P_M[d];
        if (idx >= 0) c += ((j % 2) ? -1 : 1) * binom(n, j) * m_x[d][idx];
      end
      m_c[d].push_back(wrapw(c, AW));
      m_s[d].push_back(m_beats[d]);
    end
    if (beat) begin
      if (m_phase[d] == P_R[d] - 1) begin
        m_phase[d] = 0;
        if (!acc) m_run[d] = 0;
      end else begin
        m_phase[d]++;
      end
    end else if (acc) begin
      m_run[d] = 1; m_phase[d] = 0;
    end
    e_busy[d] = m_run[d];
  endtask

  task automatic chk(string name, int d, longint act, longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, d, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    for (int d = 0; d < ND; d++) begin
      chk("o_data", d, d_data[d], e_data[d]);
      chk("o_valid", d, longint'(d_valid[d]), longint'(e_valid[d]));
      chk("o_saturate", d, longint'(d_sat[d]), longint'(e_sat[d]));
      chk("o_underrun", d, longint'(d_under[d]), longint'(e_under[d]));
      chk("o_busy", d, longint'(d_busy[d]), longint'(e_busy[d]));
    end
    if (mode == MD_IMP && d_valid[1] && d_data[1] == 100) imp_cnt++;
    if (!d_valid[0]) nv_cnt++;
    if (d_under[0]) under_cnt++;
  endtask

  task automatic pick_inputs();
    for (int d = 0; d < ND; d++) begin
      if (mode == MD_RAND) en[d] = ($urandom_range(0, 255) != 0);
      if (!(vld[d] && !last_acc[d])) begin
        case (mode)
          MD_IMP:    begin vld[d] = 1'b1; din[d] = (sent_cnt[d] == 0) ? 16'sd100 : 16'sd0; end
          MD_DC:     begin vld[d] = 1'b1; din[d] = 16'(dc_val); end
          MD_SINGLE: begin vld[d] = (sent_cnt[d] == 0); din[d] = 16'(dc_val); end
          MD_RAND:   begin vld[d] = ($urandom_range(0, 3) != 0); din[d] = 16'($urandom); end
          default:   begin vld[d] = 1'b0; din[d] = 16'sd0; end
        endcase
      end
    end
  endtask

  // Entered at a negedge: check registered outputs, drive inputs, check the
  // combinational ready, advance the model over the coming posedge.
  task automatic run_cycle();
    bit a;
    check_outputs();
    pick_inputs();
    #1;
    for (int d = 0; d < ND; d++) begin
      chk("o_ready", d, longint'(d_ready[d]), longint'(model_ready(d)));
      if (d == 0 && d_ready[0]) rdy_cnt++;
      model_step(d, en[d] && rst_n, vld[d], longint'(din[d]), a);
      last_acc[d] = a;
      if (a) sent_cnt[d]++;
    end
    @(negedge clk);
  endtask

  task automatic set_mode(int m);
    mode = m;
    for (int d = 0; d < ND; d++) begin
      sent_cnt[d] = 0; vld[d] = 1'b0; last_acc[d] = 0;
    end
  endtask

  task automatic clear_all();
    set_mode(MD_IDLE);
    for (int d = 0; d < ND; d++) en[d] = 1'b0;
    run_cycle();
    for (int d = 0; d < ND; d++) en[d] = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < ND; d++) begin
      en[d] = 1'b0; vld[d] = 1'b0; din[d] = '0; last_acc[d] = 0; sent_cnt[d] = 0;
      model_clear(d);
    end
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    for (int d = 0; d < ND; d++) en[d] = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) chk("reset_ready", d, longint'(d_ready[d]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) run_cycle();

    // Impulse 100 then zeros.
    set_mode(MD_IMP);
    imp_cnt = 0;
    repeat (60) run_cycle();
    chk("imp_count_100", 1, imp_cnt, 4);
    chk("imp_tail_zero", 1, d_data[1], 0);

    // DC +1000 streaming.
    clear_all();
    set_mode(MD_DC);
    dc_val = 1000;
    repeat (220) run_cycle();
    rdy_cnt = 0; nv_cnt = 0;
    repeat (80) run_cycle();
    chk("dc_settle", 0, d_data[0], 1000);
    chk("dc_ready_every_8", 0, rdy_cnt, 10);
    chk("dc_valid_gaps", 0, nv_cnt, 0);
    chk("dc_n1_unity", 1, d_data[1], 1000);
    chk("dc_sat_pos", 2, d_data[2], 32767);
    chk("dc_sat_flag", 2, longint'(d_sat[2]), 1);
    chk("dc_sat_pos", 3, d_data[3], 2047);

    // Enable dropped for one cycle mid-stream, then impulse from zero.
    for (int d = 0; d < ND; d++) en[d] = 1'b0;
    run_cycle();
    chk("en_clear_data", 0, d_data[0], 0);
    chk("en_clear_valid", 0, longint'(d_valid[0]), 0);
    for (int d = 0; d < ND; d++) en[d] = 1'b1;
    set_mode(MD_IMP);
    imp_cnt = 0;
    repeat (60) run_cycle();
    chk("restart_imp_count", 1, imp_cnt, 4);

    // DC -1000 streaming.
    clear_all();
    set_mode(MD_DC);
    dc_val = -1000;
    repeat (300) run_cycle();
    chk("dc_neg_settle", 0, d_data[0], -1000);
    chk("dc_sat_neg", 2, d_data[2], -32768);

    // Single sample, underrun, hold, resume.
    clear_all();
    set_mode(MD_SINGLE);
    dc_val = 300;
    under_cnt = 0;
    repeat (40) run_cycle();
    chk("single_underrun_pulses", 0, under_cnt, 1);
    chk("single_busy_low", 0, longint'(d_busy[0]), 0);
    set_mode(MD_DC);
    repeat (60) run_cycle();

    // Random data with random valid gaps and rare enable drops.
    clear_all();
    set_mode(MD_RAND);
    repeat (3000) run_cycle();
    for (int d = 0; d < ND; d++) en[d] = 1'b1;

    // Asynchronous reset mid-run.
    clear_all();
    set_mode(MD_DC);
    dc_val = 700;
    repeat (30) run_cycle();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) model_clear(d);
    check_outputs();
    for (int d = 0; d < ND; d++) chk("async_reset_ready", d, longint'(d_ready[d]), 0);
    repeat (2) run_cycle();
    rst_n = 1'b1;
    repeat (40) run_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
